// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C temperature-sensor target.
// Holds the FSM state encoding, register indices and the register read mux.
package i2c_pkg;

  localparam int I2C_ADDR_W = 7;

  localparam logic [1:0] REG_TMSB = 2'd0;
  localparam logic [1:0] REG_TLSB = 2'd1;
  localparam logic [1:0] REG_STAT = 2'd2;
  localparam logic [1:0] REG_ID   = 2'd3;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_IGNORE,
    ST_WR_PTR,
    ST_WR_ACK,
    ST_WR_DATA,
    ST_RD_BYTE,
    ST_RD_ACK
  } state_t;

  function automatic logic [7:0] reg_byte(input logic [1:0] idx,
                                          input logic [15:0] temp,
                                          input logic [7:0] stat,
                                          input logic [7:0] id);
    logic [7:0] b;
    case (idx)
      REG_TMSB: b = temp[15:8];
      REG_TLSB: b = temp[7:0];
      REG_STAT: b = stat;
      default:  b = id;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/i2c_in_cond.sv
// One bus line: 2-FF synchroniser, stability filter when I2C_GLITCH_FILTER_EN is defined, edge detect.
// Edge latency 2 clocks (2+FILT_LEN with the filter); no backpressure, edges are one-cycle strobes.
module i2c_in_cond #(
  parameter int FILT_LEN = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1;
  logic s2;
  logic prev;

  always_ff @(posedge clk) begin
    s1 <= raw;
    s2 <= s1;
  end

`ifdef I2C_GLITCH_FILTER_EN
  localparam int CW = $clog2(FILT_LEN + 1);

  logic [CW-1:0] cnt;
  logic          filt;

  // Output follows the synchronised line only after FILT_LEN consecutive differing samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      filt <= s2;
      cnt  <= '0;
    end else if (s2 == filt) begin
      cnt <= '0;
    end else if (cnt == CW'(FILT_LEN - 1)) begin
      filt <= s2;
      cnt  <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign level = filt;
`else
  // Filter length only matters when the filter is built.
  if (FILT_LEN > 0) begin : g_sync_only
    assign level = s2;
  end
`endif

  // prev tracks the line through reset so no phantom edge appears on release.
  always_ff @(posedge clk) begin
    prev <= level;
  end

  assign rise = ~reset & level & ~prev;
  assign fall = ~reset & ~level & prev;

endmodule

// File: rtl/i2c_temp_target.sv
// I2C target emulating the board temperature sensor (4-byte register map); I2C_GLITCH_FILTER_EN adds input filtering.
// Reacts 2 clocks (2+FILT_LEN filtered) after a bus edge; never stretches SCL, SDA is open-drain via sda_oe.
module i2c_temp_target
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] TARGET_ADDR = 7'h4B,
  parameter logic [7:0]            DEV_ID      = 8'hCB,
  parameter int                    FILT_LEN    = 4
) (
  input  logic        clk_100MHz,
  input  logic        reset,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_oe,
  input  logic [15:0] temp_data,
  input  logic [7:0]  status,
  output logic        busy,
  output logic        wr_valid,
  output logic [7:0]  wr_data
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_in_cond #(.FILT_LEN(FILT_LEN)) u_scl (
    .clk   (clk_100MHz),
    .reset (reset),
    .raw   (scl_in),
    .level (scl_lvl),
    .rise  (scl_rise),
    .fall  (scl_fall)
  );

  i2c_in_cond #(.FILT_LEN(FILT_LEN)) u_sda (
    .clk   (clk_100MHz),
    .reset (reset),
    .raw   (sda_in),
    .level (sda_lvl),
    .rise  (sda_rise),
    .fall  (sda_fall)
  );

  logic start_det;
  logic stop_det;

  assign start_det = scl_lvl & sda_fall;
  assign stop_det  = scl_lvl & sda_rise;

  state_t      state;
  logic [7:0]  rx;
  logic [7:0]  tx;
  logic [3:0]  bit_cnt;
  logic [1:0]  ptr;
  logic [15:0] shadow;
  logic        is_rd;
  logic [7:0]  rd_byte;

  assign rd_byte = reg_byte(ptr, shadow, status, DEV_ID);

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      state    <= ST_IDLE;
      sda_oe   <= 1'b0;
      busy     <= 1'b0;
      wr_valid <= 1'b0;
      wr_data  <= 8'h00;
      ptr      <= REG_TMSB;
      rx       <= 8'h00;
      tx       <= 8'h00;
      bit_cnt  <= 4'd0;
      shadow   <= 16'h0000;
      is_rd    <= 1'b0;
    end else begin
      wr_valid <= 1'b0;
      if (stop_det) begin
        state  <= ST_IDLE;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
      end else if (start_det) begin
        state   <= ST_ADDR;
        sda_oe  <= 1'b0;
        bit_cnt <= 4'd0;
      end else begin
        case (state)
          ST_ADDR: begin
            if (scl_rise) begin
              rx      <= {rx[6:0], sda_lvl};
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              bit_cnt <= 4'd0;
              if (rx[7:1] == TARGET_ADDR) begin
                sda_oe <= 1'b1;
                busy   <= 1'b1;
                is_rd  <= rx[0];
                state  <= ST_ADDR_ACK;
                if (rx[0]) shadow <= temp_data;
              end else begin
                busy  <= 1'b0;
                state <= ST_IGNORE;
              end
            end
          end

          ST_ADDR_ACK: begin
            if (scl_fall) begin
              bit_cnt <= 4'd0;
              if (is_rd) begin
                tx     <= rd_byte;
                sda_oe <= ~rd_byte[7];
                state  <= ST_RD_BYTE;
              end else begin
                sda_oe <= 1'b0;
                state  <= ST_WR_PTR;
              end
            end
          end

          ST_WR_PTR: begin
            if (scl_rise) begin
              rx      <= {rx[6:0], sda_lvl};
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              ptr    <= rx[1:0];
              sda_oe <= 1'b1;
              state  <= ST_WR_ACK;
            end
          end

          ST_WR_ACK: begin
            if (scl_fall) begin
              sda_oe  <= 1'b0;
              bit_cnt <= 4'd0;
              state   <= ST_WR_DATA;
            end
          end

          ST_WR_DATA: begin
            if (scl_rise) begin
              rx      <= {rx[6:0], sda_lvl};
              bit_cnt <= bit_cnt + 4'd1;
              // Report the byte as soon as its last bit is in, ahead of the ACK.
              if (bit_cnt == 4'd7) begin
                wr_valid <= 1'b1;
                wr_data  <= {rx[6:0], sda_lvl};
                ptr      <= ptr + 2'd1;
              end
            end else if (scl_fall && bit_cnt == 4'd8) begin
              sda_oe <= 1'b1;
              state  <= ST_WR_ACK;
            end
          end

          ST_RD_BYTE: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                sda_oe  <= 1'b0;
                ptr     <= ptr + 2'd1;
                bit_cnt <= 4'd0;
                state   <= ST_RD_ACK;
              end else begin
                sda_oe <= ~tx[6];
                tx     <= {tx[6:0], 1'b0};
              end
            end
          end

          ST_RD_ACK: begin
            // bit_cnt marks that the master's ACK bit has been sampled.
            if (scl_rise) begin
              if (sda_lvl) state <= ST_IGNORE;
              else bit_cnt <= 4'd1;
            end else if (scl_fall && bit_cnt == 4'd1) begin
              tx      <= rd_byte;
              sda_oe  <= ~rd_byte[7];
              bit_cnt <= 4'd0;
              state   <= ST_RD_BYTE;
            end
          end

          default: ;
        endcase
      end
    end
  end

endmodule
